// File: rtl/k423_mem_stage_lsu_if.sv
// Bundle of EX -> MEM -> WB signals plus the data-memory response for the k423 MEM stage.
// Handshake: a result moves to WB when mem_stage_vld_o & wb_stage_rdy_i; EX holds ex_* while ex_stage_vld_i & ~mem_stage_rdy_o.
interface k423_mem_stage_lsu_if #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int RSDIDX_W = 5
);
  logic                ex_stage_vld_i;
  logic                mem_stage_vld_o;
  logic                mem_stage_rdy_o;
  logic                wb_stage_rdy_i;
  logic [ADDR_W-1:0]   ex_pc_i;
  logic                ex_rd_vld_i;
  logic [RSDIDX_W-1:0] ex_rd_idx_i;
  logic [XLEN-1:0]     ex_rd_i;
  logic                ex_rd_load_i;
  logic [1:0]          ex_rd_load_size_i;
  logic                ex_rd_load_unsigned_i;
  logic [ADDR_W-1:0]   ex_rd_load_addr_i;
  logic                ex_bju_br_tkn_i;
  logic [XLEN-1:0]     ex_bju_br_pc_i;
  logic                mem_data_rsp_vld_i;
  logic [XLEN-1:0]     mem_data_rsp_rdata_i;
  logic                mem_data_rsp_err_i;
  logic [ADDR_W-1:0]   mem_pc_o;
  logic                mem_rd_vld_o;
  logic [RSDIDX_W-1:0] mem_rd_idx_o;
  logic [XLEN-1:0]     mem_rd_o;
  logic                mem_bju_br_tkn_o;
  logic [XLEN-1:0]     mem_bju_br_pc_o;
  logic                mem_excp_misalign_o;
  logic                mem_excp_fault_o;
  logic [1:0]          dbg_state;

  modport master (
    output ex_stage_vld_i, wb_stage_rdy_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i,
           ex_rd_load_i, ex_rd_load_size_i, ex_rd_load_unsigned_i, ex_rd_load_addr_i,
           ex_bju_br_tkn_i, ex_bju_br_pc_i, mem_data_rsp_vld_i, mem_data_rsp_rdata_i, mem_data_rsp_err_i,
    input  mem_stage_vld_o, mem_stage_rdy_o, mem_pc_o, mem_rd_vld_o, mem_rd_idx_o, mem_rd_o,
           mem_bju_br_tkn_o, mem_bju_br_pc_o, mem_excp_misalign_o, mem_excp_fault_o, dbg_state
  );

  modport slave (
    input  ex_stage_vld_i, wb_stage_rdy_i, ex_pc_i, ex_rd_vld_i, ex_rd_idx_i, ex_rd_i,
           ex_rd_load_i, ex_rd_load_size_i, ex_rd_load_unsigned_i, ex_rd_load_addr_i,
           ex_bju_br_tkn_i, ex_bju_br_pc_i, mem_data_rsp_vld_i, mem_data_rsp_rdata_i, mem_data_rsp_err_i,
    output mem_stage_vld_o, mem_stage_rdy_o, mem_pc_o, mem_rd_vld_o, mem_rd_idx_o, mem_rd_o,
           mem_bju_br_tkn_o, mem_bju_br_pc_o, mem_excp_misalign_o, mem_excp_fault_o, dbg_state
  );
endinterface

// File: rtl/k423_mem_stage_lsu.sv
// k423 MEM stage: waits for the data-memory response on loads, extracts/extends load data,
// holds a response across WB stalls, and flags misaligned / faulting loads (incl. timeout).
module k423_mem_stage_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int RSDIDX_W    = 5,
  parameter int RSP_TIMEOUT = 255
) (
  input logic                 clk_i,
  input logic                 rst_i,
  k423_mem_stage_lsu_if.slave bus
);
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;
  localparam int CNT_W = $clog2(RSP_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(RSP_TIMEOUT);
  localparam bit TMO_EN = (RSP_TIMEOUT != 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             stale;
  logic [XLEN-1:0]  hold_data;
  logic             hold_fault;
  logic             hold_rd_vld;

  logic             is_load, misalign, aligned_load;
  logic             rsp_hit, timeout_hit, done, fault_now, consume;
  logic [2:0]       addr_lo;
  logic [OFF_W-1:0] off, lane_mask, off_m;
  logic [63:0]      shifted, ext64;
  logic [XLEN-1:0]  load_data;
  logic             sx;
  logic             unused_ok;

  assign is_load = bus.ex_rd_load_i;
  assign addr_lo = bus.ex_rd_load_addr_i[2:0];

  always_comb begin
    misalign = 1'b0;
    case (bus.ex_rd_load_size_i)
      2'b01:   misalign = addr_lo[0];
      2'b10:   misalign = |addr_lo[1:0];
      2'b11:   misalign = (XLEN == 32) || (|addr_lo);
      default: misalign = 1'b0;
    endcase
    misalign = misalign & is_load;
  end

  assign aligned_load = bus.ex_stage_vld_i & is_load & ~misalign;

  // A response while stale belongs to a load that already timed out; it never counts.
  assign rsp_hit = bus.mem_data_rsp_vld_i & ~stale & aligned_load & (state != S_HOLD);
  assign timeout_hit = TMO_EN && (state == S_WAIT) && (cnt == TMO_VAL) && !rsp_hit;

  assign done = ~is_load | misalign | rsp_hit | (state == S_HOLD) | timeout_hit;

  assign bus.mem_stage_vld_o = ~rst_i & bus.ex_stage_vld_i & done;
  assign bus.mem_stage_rdy_o = ~rst_i & (~bus.ex_stage_vld_i | (done & bus.wb_stage_rdy_i));
  assign consume = bus.ex_stage_vld_i & bus.mem_stage_rdy_o;

  assign fault_now = (state == S_HOLD) ? hold_fault
                                       : (timeout_hit | (rsp_hit & bus.mem_data_rsp_err_i));

  // Low lane bits are masked per size so the shift always lands on the naturally aligned lane.
  assign off       = bus.ex_rd_load_addr_i[OFF_W-1:0];
  assign lane_mask = OFF_W'((4'd1 << bus.ex_rd_load_size_i) - 4'd1);
  assign off_m     = off & ~lane_mask;
  assign shifted   = 64'(bus.mem_data_rsp_rdata_i) >> {off_m, 3'b000};
  assign sx        = ~bus.ex_rd_load_unsigned_i;

  always_comb begin
    case (bus.ex_rd_load_size_i)
      2'b00:   ext64 = {{56{sx & shifted[7]}},  shifted[7:0]};
      2'b01:   ext64 = {{48{sx & shifted[15]}}, shifted[15:0]};
      2'b10:   ext64 = {{32{sx & shifted[31]}}, shifted[31:0]};
      default: ext64 = shifted;
    endcase
  end

  assign load_data = ext64[XLEN-1:0];

  always_comb begin
    bus.mem_rd_o            = bus.ex_rd_i;
    bus.mem_rd_vld_o        = bus.ex_rd_vld_i;
    bus.mem_rd_idx_o        = bus.ex_rd_idx_i;
    bus.mem_excp_misalign_o = 1'b0;
    bus.mem_excp_fault_o    = 1'b0;
    if (is_load) begin
      if (misalign) begin
        bus.mem_rd_o            = '0;
        bus.mem_rd_vld_o        = 1'b0;
        bus.mem_excp_misalign_o = 1'b1;
      end else if (fault_now) begin
        bus.mem_rd_o         = '0;
        bus.mem_rd_vld_o     = 1'b0;
        bus.mem_excp_fault_o = 1'b1;
      end else if (state == S_HOLD) begin
        bus.mem_rd_o     = hold_data;
        bus.mem_rd_vld_o = hold_rd_vld;
      end else begin
        bus.mem_rd_o = load_data;
      end
    end
    if (rst_i) begin
      bus.mem_rd_o            = '0;
      bus.mem_rd_vld_o        = 1'b0;
      bus.mem_rd_idx_o        = '0;
      bus.mem_excp_misalign_o = 1'b0;
      bus.mem_excp_fault_o    = 1'b0;
    end
  end

  assign bus.mem_pc_o         = bus.ex_pc_i;
  assign bus.mem_bju_br_tkn_o = bus.ex_bju_br_tkn_i;
  assign bus.mem_bju_br_pc_o  = bus.ex_bju_br_pc_i;
  assign bus.dbg_state        = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      stale       <= 1'b0;
      hold_data   <= '0;
      hold_fault  <= 1'b0;
      hold_rd_vld <= 1'b0;
    end else begin
      if (timeout_hit) begin
        stale <= 1'b1;
      end else if (bus.mem_data_rsp_vld_i && stale) begin
        stale <= 1'b0;
      end
      case (state)
        S_IDLE, S_WAIT: begin
          if (aligned_load) begin
            if (rsp_hit || timeout_hit) begin
              cnt <= '0;
              if (bus.wb_stage_rdy_i) begin
                state <= S_IDLE;
              end else begin
                state       <= S_HOLD;
                hold_data   <= load_data;
                hold_fault  <= fault_now;
                hold_rd_vld <= bus.ex_rd_vld_i & ~fault_now;
              end
            end else if (state == S_IDLE) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(1);
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (consume) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign unused_ok = ^{bus.ex_rd_load_addr_i, ext64};
endmodule

// File: tb/tb_k423_mem_stage_lsu.sv
// Bench for k423_mem_stage_lsu: one XLEN=32 and one XLEN=64 instance (RSP_TIMEOUT=4) driven from shared stimulus.
module tb_k423_mem_stage_lsu;
  localparam int TMO = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus; t_sel picks the 64-bit instance
  logic        t_sel, t_vld, t_load, t_uns, t_rd_vld, t_rsp, t_err, wb_rdy, t_br_tkn;
  logic [1:0]  t_size;
  logic [31:0] t_addr, t_pc;
  logic [63:0] t_rd, t_rdata, t_br_pc;
  logic [4:0]  t_idx;

  k423_mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32), .RSDIDX_W(5)) b32 ();
  k423_mem_stage_lsu_if #(.XLEN(64), .ADDR_W(32), .RSDIDX_W(5)) b64 ();

  k423_mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .RSDIDX_W(5), .RSP_TIMEOUT(TMO)) u32 (
    .clk_i(clk), .rst_i(rst), .bus(b32.slave));
  k423_mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .RSDIDX_W(5), .RSP_TIMEOUT(TMO)) u64 (
    .clk_i(clk), .rst_i(rst), .bus(b64.slave));

  assign b32.ex_stage_vld_i        = t_vld & ~t_sel;
  assign b32.mem_data_rsp_vld_i    = t_rsp & ~t_sel;
  assign b32.wb_stage_rdy_i        = wb_rdy;
  assign b32.ex_pc_i               = t_pc;
  assign b32.ex_rd_vld_i           = t_rd_vld;
  assign b32.ex_rd_idx_i           = t_idx;
  assign b32.ex_rd_i               = t_rd[31:0];
  assign b32.ex_rd_load_i          = t_load;
  assign b32.ex_rd_load_size_i     = t_size;
  assign b32.ex_rd_load_unsigned_i = t_uns;
  assign b32.ex_rd_load_addr_i     = t_addr;
  assign b32.ex_bju_br_tkn_i       = t_br_tkn;
  assign b32.ex_bju_br_pc_i        = t_br_pc[31:0];
  assign b32.mem_data_rsp_rdata_i  = t_rdata[31:0];
  assign b32.mem_data_rsp_err_i    = t_err;

  assign b64.ex_stage_vld_i        = t_vld & t_sel;
  assign b64.mem_data_rsp_vld_i    = t_rsp & t_sel;
  assign b64.wb_stage_rdy_i        = wb_rdy;
  assign b64.ex_pc_i               = t_pc;
  assign b64.ex_rd_vld_i           = t_rd_vld;
  assign b64.ex_rd_idx_i           = t_idx;
  assign b64.ex_rd_i               = t_rd;
  assign b64.ex_rd_load_i          = t_load;
  assign b64.ex_rd_load_size_i     = t_size;
  assign b64.ex_rd_load_unsigned_i = t_uns;
  assign b64.ex_rd_load_addr_i     = t_addr;
  assign b64.ex_bju_br_tkn_i       = t_br_tkn;
  assign b64.ex_bju_br_pc_i        = t_br_pc;
  assign b64.mem_data_rsp_rdata_i  = t_rdata;
  assign b64.mem_data_rsp_err_i    = t_err;

  logic        o_vld, o_rdy, o_rd_vld, o_mis, o_flt;
  logic [63:0] o_rd;
  logic [1:0]  o_state;
  assign o_vld    = t_sel ? b64.mem_stage_vld_o     : b32.mem_stage_vld_o;
  assign o_rdy    = t_sel ? b64.mem_stage_rdy_o     : b32.mem_stage_rdy_o;
  assign o_rd_vld = t_sel ? b64.mem_rd_vld_o        : b32.mem_rd_vld_o;
  assign o_mis    = t_sel ? b64.mem_excp_misalign_o : b32.mem_excp_misalign_o;
  assign o_flt    = t_sel ? b64.mem_excp_fault_o    : b32.mem_excp_fault_o;
  assign o_rd     = t_sel ? b64.mem_rd_o            : {32'h0, b32.mem_rd_o};
  assign o_state  = t_sel ? b64.dbg_state           : b32.dbg_state;

  // scoreboard: {rd_vld, rd, misalign, fault}
  int checks = 0;
  int errors = 0;
  logic [66:0] exp_q[$];
  logic [66:0] sb_e;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_vld && wb_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result 0x%0h with no expected entry", o_rd);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_result", {o_rd_vld, o_rd, o_mis, o_flt}, sb_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  // driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_vld = 1'b0; t_load = 1'b0; t_uns = 1'b0; t_rd_vld = 1'b0; t_rsp = 1'b0; t_err = 1'b0;
    t_size = 2'd0; t_addr = 32'h0; t_rd = 64'h0; t_rdata = 64'h0;
    t_br_tkn = 1'b0; t_br_pc = 64'h0; t_pc = 32'h0; t_idx = 5'd0;
  endtask

  task automatic load_in(input logic [1:0] size, input logic uns, input logic [31:0] addr);
    t_vld = 1'b1; t_load = 1'b1; t_size = size; t_uns = uns; t_addr = addr;
    t_rd_vld = 1'b1; t_rd = 64'h0; t_rsp = 1'b0; t_err = 1'b0; t_idx = 5'd9;
  endtask

  typedef struct {
    logic        sel, vld, load;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [63:0] rd;
    logic        rd_vld, rsp;
    logic [63:0] rdata;
    logic        err;
    logic        e_vld, e_rd_vld;
    logic [63:0] e_rd;
    logic        e_mis, e_flt;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];
  logic [63:0] hold_exp;

  initial begin
    vt[0]  = '{1'b0,1'b1,1'b0,2'd0,1'b0,32'h0,   64'h1234,1'b1,1'b0,64'h0,                 1'b0, 1'b1,1'b1,64'h1234,              1'b0,1'b0};
    vt[1]  = '{1'b0,1'b1,1'b1,2'd0,1'b0,32'h3,   64'h0,   1'b1,1'b1,64'h80FF0000,          1'b0, 1'b1,1'b1,64'hFFFFFF80,          1'b0,1'b0};
    vt[2]  = '{1'b0,1'b1,1'b1,2'd0,1'b1,32'h3,   64'h0,   1'b1,1'b1,64'h80FF0000,          1'b0, 1'b1,1'b1,64'h80,                1'b0,1'b0};
    vt[3]  = '{1'b0,1'b1,1'b1,2'd1,1'b0,32'h2,   64'h0,   1'b1,1'b1,64'h80011234,          1'b0, 1'b1,1'b1,64'hFFFF8001,          1'b0,1'b0};
    vt[4]  = '{1'b0,1'b1,1'b1,2'd1,1'b1,32'h2,   64'h0,   1'b1,1'b1,64'h80011234,          1'b0, 1'b1,1'b1,64'h8001,              1'b0,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b1,2'd1,1'b0,32'h0,   64'h0,   1'b1,1'b1,64'h00007FFE,          1'b0, 1'b1,1'b1,64'h7FFE,              1'b0,1'b0};
    vt[6]  = '{1'b0,1'b1,1'b1,2'd2,1'b1,32'h100, 64'h0,   1'b1,1'b1,64'hDEADBEEF,          1'b0, 1'b1,1'b1,64'hDEADBEEF,          1'b0,1'b0};
    vt[7]  = '{1'b0,1'b1,1'b1,2'd2,1'b0,32'h1002,64'h0,   1'b1,1'b0,64'h0,                 1'b0, 1'b1,1'b0,64'h0,                 1'b1,1'b0};
    vt[8]  = '{1'b0,1'b1,1'b1,2'd1,1'b0,32'h1001,64'h0,   1'b1,1'b0,64'h0,                 1'b0, 1'b1,1'b0,64'h0,                 1'b1,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b1,2'd3,1'b0,32'h0,   64'h0,   1'b1,1'b0,64'h0,                 1'b0, 1'b1,1'b0,64'h0,                 1'b1,1'b0};
    vt[10] = '{1'b0,1'b1,1'b1,2'd0,1'b0,32'h1,   64'h0,   1'b1,1'b1,64'h1234FFFF,          1'b1, 1'b1,1'b0,64'h0,                 1'b0,1'b1};
    vt[11] = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,   64'h0,   1'b0,1'b1,64'h5A5A,              1'b0, 1'b0,1'b0,64'h0,                 1'b0,1'b0};
    vt[12] = '{1'b0,1'b1,1'b0,2'd0,1'b0,32'h0,   64'hABCD,1'b0,1'b0,64'h0,                 1'b0, 1'b1,1'b0,64'hABCD,              1'b0,1'b0};
    vt[13] = '{1'b0,1'b1,1'b1,2'd0,1'b0,32'h2,   64'h0,   1'b1,1'b1,64'h007F0000,          1'b0, 1'b1,1'b1,64'h7F,                1'b0,1'b0};
    vt[14] = '{1'b1,1'b1,1'b1,2'd2,1'b0,32'h4,   64'h0,   1'b1,1'b1,64'h8000000011111111,  1'b0, 1'b1,1'b1,64'hFFFFFFFF80000000,  1'b0,1'b0};
    vt[15] = '{1'b1,1'b1,1'b1,2'd2,1'b1,32'h4,   64'h0,   1'b1,1'b1,64'h8000000011111111,  1'b0, 1'b1,1'b1,64'h0000000080000000,  1'b0,1'b0};
    vt[16] = '{1'b1,1'b1,1'b1,2'd3,1'b0,32'h3,   64'h0,   1'b1,1'b0,64'h0,                 1'b0, 1'b1,1'b0,64'h0,                 1'b1,1'b0};
    vt[17] = '{1'b1,1'b1,1'b1,2'd0,1'b0,32'h7,   64'h0,   1'b1,1'b1,64'hFE00000000000000,  1'b0, 1'b1,1'b1,64'hFFFFFFFFFFFFFFFE,  1'b0,1'b0};
    vt[18] = '{1'b1,1'b1,1'b1,2'd3,1'b1,32'h8,   64'h0,   1'b1,1'b1,64'h8000000000000001,  1'b0, 1'b1,1'b1,64'h8000000000000001,  1'b0,1'b0};
    vt[19] = '{1'b1,1'b1,1'b1,2'd1,1'b0,32'h6,   64'h0,   1'b1,1'b1,64'h8123000000000000,  1'b0, 1'b1,1'b1,64'hFFFFFFFFFFFF8123,  1'b0,1'b0};

    // reset with a valid non-load presented
    rst = 1'b1; wb_rdy = 1'b1; t_sel = 1'b0; idle_inputs();
    t_vld = 1'b1; t_rd = 64'h1234; t_rd_vld = 1'b1;
    repeat (2) next_cyc();
    #3;
    chk("rst_vld", o_vld, 0);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_rd_vld", o_rd_vld, 0);
    chk("rst_state", o_state, ST_IDLE);
    next_cyc();
    rst = 1'b0; idle_inputs();

    // pass-through of pc / idx / branch
    next_cyc();
    t_vld = 1'b1; t_rd = 64'h55; t_rd_vld = 1'b1; t_pc = 32'h400; t_idx = 5'd7;
    t_br_tkn = 1'b1; t_br_pc = 64'hCAFE0000;
    exp_q.push_back({1'b1, 64'h55, 2'b00});
    #3;
    chk("pt_pc", b32.mem_pc_o, 32'h400);
    chk("pt_idx", b32.mem_rd_idx_o, 5'd7);
    chk("pt_br_tkn", b32.mem_bju_br_tkn_o, 1'b1);
    chk("pt_br_pc", b32.mem_bju_br_pc_o, 32'hCAFE0000);

    // single-cycle table
    for (int i = 0; i < NV; i++) begin
      next_cyc();
      idle_inputs();
      t_sel = vt[i].sel; t_vld = vt[i].vld; t_load = vt[i].load; t_size = vt[i].size;
      t_uns = vt[i].uns; t_addr = vt[i].addr; t_rd = vt[i].rd; t_rd_vld = vt[i].rd_vld;
      t_rsp = vt[i].rsp; t_rdata = vt[i].rdata; t_err = vt[i].err;
      if (vt[i].e_vld) exp_q.push_back({vt[i].e_rd_vld, vt[i].e_rd, vt[i].e_mis, vt[i].e_flt});
      #3;
      chk($sformatf("vec%0d_vld", i), o_vld, vt[i].e_vld);
      chk($sformatf("vec%0d_rdy", i), o_rdy, 1'b1);
      chk($sformatf("vec%0d_state", i), o_state, ST_IDLE);
    end

    // delayed LB / LBU: three WAIT cycles, response in the third
    for (int u = 0; u < 2; u++) begin
      next_cyc();
      idle_inputs(); t_sel = 1'b0;
      load_in(2'd0, u[0], 32'h3);
      #3;
      chk("dly_present_vld", o_vld, 0);
      chk("dly_present_rdy", o_rdy, 0);
      for (int c = 1; c <= 2; c++) begin
        next_cyc();
        t_rdata = 64'($urandom);
        #3;
        chk("dly_wait_vld", o_vld, 0);
        chk("dly_wait_state", o_state, ST_WAIT);
      end
      next_cyc();
      t_rsp = 1'b1; t_rdata = 64'h80FF0000;
      exp_q.push_back({1'b1, (u == 0) ? 64'hFFFFFF80 : 64'h80, 2'b00});
      #3;
      chk("dly_rsp_vld", o_vld, 1);
      chk("dly_rsp_state", o_state, ST_WAIT);
      next_cyc();
      idle_inputs();
      #3;
      chk("dly_done_state", o_state, ST_IDLE);
    end

    // response during a WB stall is latched in HOLD while the bus shows garbage
    next_cyc();
    idle_inputs(); t_sel = 1'b0; wb_rdy = 1'b0;
    load_in(2'd2, 1'b0, 32'h20);
    next_cyc();
    #3;
    chk("stall_wait_state", o_state, ST_WAIT);
    next_cyc();
    t_rsp = 1'b1; t_rdata = 64'h13579BDF;
    hold_exp = 64'h13579BDF;
    exp_q.push_back({1'b1, hold_exp, 2'b00});
    #3;
    chk("stall_rsp_vld", o_vld, 1);
    chk("stall_rsp_rdy", o_rdy, 0);
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      t_rsp = 1'b0; t_rdata = {$urandom, $urandom};
      #3;
      chk("stall_hold_state", o_state, ST_HOLD);
      chk("stall_hold_vld", o_vld, 1);
      chk("stall_hold_rdy", o_rdy, 0);
      chk("stall_hold_rd", o_rd, hold_exp);
    end
    next_cyc();
    wb_rdy = 1'b1; t_rdata = {$urandom, $urandom};
    #3;
    chk("stall_release_rdy", o_rdy, 1);
    next_cyc();
    idle_inputs();
    #3;
    chk("stall_after_state", o_state, ST_IDLE);

    // 64-bit timeout, late response dropped, next LD completes normally
    next_cyc();
    idle_inputs(); t_sel = 1'b1;
    load_in(2'd3, 1'b0, 32'h10);
    #3;
    chk("tmo_present_vld", o_vld, 0);
    for (int c = 1; c <= 3; c++) begin
      next_cyc();
      #3;
      chk("tmo_wait_vld", o_vld, 0);
      chk("tmo_wait_state", o_state, ST_WAIT);
    end
    next_cyc();
    exp_q.push_back({1'b0, 64'h0, 2'b01});
    #3;
    chk("tmo_fire_vld", o_vld, 1);
    chk("tmo_fire_fault", o_flt, 1);
    next_cyc();
    load_in(2'd3, 1'b0, 32'h18);
    #3;
    chk("tmo_next_state", o_state, ST_IDLE);
    chk("tmo_next_vld", o_vld, 0);
    next_cyc();
    t_rsp = 1'b1; t_rdata = 64'hBAD;
    #3;
    chk("tmo_late_dropped", o_vld, 0);
    chk("tmo_late_state", o_state, ST_WAIT);
    next_cyc();
    t_rsp = 1'b1; t_rdata = 64'h8000000000000001;
    exp_q.push_back({1'b1, 64'h8000000000000001, 2'b00});
    #3;
    chk("tmo_ld_vld", o_vld, 1);
    next_cyc();
    idle_inputs();

    // delayed bus error
    next_cyc();
    idle_inputs(); t_sel = 1'b0;
    load_in(2'd1, 1'b0, 32'h2);
    next_cyc();
    t_rsp = 1'b1; t_err = 1'b1; t_rdata = 64'h7777;
    exp_q.push_back({1'b0, 64'h0, 2'b01});
    #3;
    chk("err_vld", o_vld, 1);
    chk("err_rd_vld", o_rd_vld, 0);

    // reset while in WAIT, response arriving in the reset cycle
    next_cyc();
    load_in(2'd2, 1'b0, 32'h30);
    next_cyc();
    #3;
    chk("rstw_state", o_state, ST_WAIT);
    next_cyc();
    rst = 1'b1; t_rsp = 1'b1; t_rdata = 64'h1111;
    #3;
    chk("rstw_vld", o_vld, 0);
    chk("rstw_rdy", o_rdy, 0);
    chk("rstw_rd", o_rd, 0);
    chk("rstw_excp", {o_mis, o_flt}, 0);
    next_cyc();
    rst = 1'b0; idle_inputs();
    #3;
    chk("rstw_after_state", o_state, ST_IDLE);
    chk("rstw_after_vld", o_vld, 0);
    next_cyc();
    load_in(2'd2, 1'b0, 32'h30);
    t_rsp = 1'b1; t_rdata = 64'h77;
    exp_q.push_back({1'b1, 64'h77, 2'b00});
    #3;
    chk("rstw_reload_vld", o_vld, 1);
    next_cyc();
    idle_inputs();

    repeat (2) next_cyc();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/k423_mem_stage_lsu.md
# k423_mem_stage_lsu

Parametrised memory-access stage between EX and WB of the k423 core. Waits for the data-memory response on loads instead of assuming same-cycle data, and buffers a response that arrives while WB stalls. Extracts and extends loads for XLEN=32 or 64 (LB/LBU/LH/LHU/LW/LWU/LD), and flags misaligned-load and load-fault exceptions, including a response timeout. Branch resolution from EX passes through unchanged.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- ADDR_W, 32: address / PC width.
- RSDIDX_W, 5: register index width.
- RSP_TIMEOUT, 255: maximum number of cycles spent in WAIT before a fault. 0 disables the timeout.

- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  synchronous, active-high reset
- ex_stage_vld_i  in  1  EX payload valid; all ex_* inputs are held stable until consumed
- mem_stage_vld_o  out  1  MEM result valid to WB
- mem_stage_rdy_o  out  1  MEM can consume the EX payload this cycle
- wb_stage_rdy_i  in  1  WB accepts the result
- ex_pc_i  in  ADDR_W  instruction PC
- ex_rd_vld_i / ex_rd_idx_i / ex_rd_i  in  1 / RSDIDX_W / XLEN  destination write-enable, index, ALU result
- ex_rd_load_i  in  1  instruction is a load
- ex_rd_load_size_i  in  2  00 byte, 01 half, 10 word, 11 double
- ex_rd_load_unsigned_i  in  1  zero-extend
- ex_rd_load_addr_i  in  ADDR_W  load byte address
- ex_bju_br_tkn_i / ex_bju_br_pc_i  in  1 / XLEN  branch taken / target
- mem_data_rsp_vld_i  in  1  single-cycle response pulse; not back-pressurable
- mem_data_rsp_rdata_i  in  XLEN  response data, naturally aligned bus word
- mem_data_rsp_err_i  in  1  bus error, qualified by rsp_vld
- mem_pc_o, mem_rd_vld_o, mem_rd_idx_o, mem_rd_o  out  ADDR_W, 1, RSDIDX_W, XLEN  result to WB
- mem_bju_br_tkn_o / mem_bju_br_pc_o  out  1 / XLEN  combinational pass-through
- mem_excp_misalign_o  out  1  misaligned or illegal-size load
- mem_excp_fault_o  out  1  bus error or timeout

## Operation
**Misalignment**
- A load is misaligned on any of these: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0; size 11 when XLEN=32.
- EX issues no request for a misaligned load.

**Done conditions**
- `done` is asserted for a non-load, a misaligned load, a response this cycle, HOLD, or a timeout this cycle.
- mem_stage_vld_o = ex_stage_vld_i & done.
- mem_stage_rdy_o = ~ex_stage_vld_i | (done & wb_stage_rdy_i).
- Consume = ex_stage_vld_i & mem_stage_rdy_o.

**FSM states**
- IDLE: no aligned load outstanding.
- WAIT: aligned load presented, no response yet.
- HOLD: response or timeout latched, waiting on WB.

**FSM transitions**
- IDLE, aligned load, no response → WAIT; timeout counter loads 1.
- IDLE or WAIT, response or timeout, WB ready → IDLE (consumed).
- IDLE or WAIT, response or timeout, WB not ready → HOLD. Latch the extracted data, the fault flag, and the rd_vld mask.
- HOLD, consume → IDLE.

**Load data path**
- Lane offset is addr[log2(XLEN/8)-1:0].
- Byte: rdata[8·off +: 8]. Half: rdata[16·off[..:1] +: 16]. Word: rdata[32·off[..:2] +: 32]. Double: full rdata.
- Sign-extend unless unsigned; unsigned is ignored for word when XLEN=32 and for double.
- Non-load: mem_rd_o = ex_rd_i.
- In HOLD, mem_rd_o comes from the latch, not from the live bus.

**Exceptions**
- A misaligned load or any fault forces mem_rd_vld_o=0 and mem_rd_o=0. An exception flag is meaningful only while mem_stage_vld_o=1.
- Timeout: in WAIT, when the counter equals RSP_TIMEOUT and no response arrives that cycle → done with a fault. The `stale` flag is set at that point.
- While `stale` is set, the next mem_data_rsp_vld_i is discarded and clears `stale`; it is never delivered as a response. Memory is in order, so this response belongs to the timed-out load.

**Pass-through**
- mem_pc_o, mem_rd_idx_o, and the branch outputs follow the ex_* inputs combinationally.

## Timing
- Non-load or misaligned load: 0-cycle, combinational, as before.
- Load whose response arrives in the presentation cycle: 0 cycles.
- Other loads: completion in the cycle the response arrives, or at the earliest the cycle after if WB stalls (via HOLD).
- While rst_i=1: state=IDLE, counter=0, stale=0, latch=0; mem_stage_vld_o=0, mem_stage_rdy_o=0, all exception and rd outputs 0.
- Reset mid-WAIT or mid-HOLD abandons the instruction. A response arriving after reset is ignored only if it arrives in a reset cycle.
- A response in a cycle where ex_stage_vld_i=0 and stale=0 is a protocol error; it is dropped with no state change.

## Test plan
- **Non-load pass-through:** ADD with ex_rd_i=0x1234, WB ready → vld_o=1, rdy_o=1, mem_rd_o=0x1234 in the same cycle.
- **Load byte, XLEN=32:** LB addr=0x...3, rdata=0x80FF_0000 arriving 3 cycles later → WAIT for 3 cycles, then mem_rd_o=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- **Response during WB stall:** response in cycle 2, wb_stage_rdy_i=0 for 4 cycles → HOLD. The rdata bus changes to garbage, yet mem_rd_o stays latched; consume occurs on the first wb_rdy cycle.
- **Misaligned load:** LW addr=0x1002 → vld_o=1 immediately, mem_excp_misalign_o=1, mem_rd_vld_o=0, no WAIT entered.
- **Timeout then late response, RSP_TIMEOUT=4:** no response → fault on the 4th WAIT cycle. The late response 2 cycles later is dropped. The next LD, XLEN=64, with rdata=0x8000_0000_0000_0001 → 0x8000_0000_0000_0001.
- **Bus error and reset:** rsp_err=1 → fault=1, rd_vld_o=0. rst_i asserted in WAIT → IDLE next cycle, all outputs 0.
